// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch feeding decode through a 2-entry {pc, instr} FIFO.
// Requests are credit-limited so outstanding fetches plus queued instructions never exceed two.
// A redirect flushes the FIFO and turns in-flight responses into drops.
// Optional build macro FETCH_MISALIGN_CHK_EN: a misaligned redirect target halts fetch and
// raises fetch_misalign; otherwise the low two target bits are forced to zero.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [6:0]  dec_opcode,
  output logic [2:0]  dec_funct3,
  output logic [6:0]  dec_funct7,
  output logic        fetch_misalign
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 3;

  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  w_fetch_pc_nxt;
  logic [XLEN-1:0]  r_fifo_pc    [DEPTH];
  logic [XLEN-1:0]  r_fifo_instr [DEPTH];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic [1:0]       w_count_nxt;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] w_outstanding_nxt;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] w_drop_nxt;

  logic             w_pop;
  logic             w_push;
  logic             w_rsp_drop;
  logic             w_rsp_keep;
  logic             w_issue;
  logic             w_halted;
  logic [CNT_W:0]   w_credit;
  logic [XLEN-1:0]  w_redirect_pc;
  logic [XLEN-1:0]  w_rsp_pc;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;

  // Sticky misalign trap: set by a misaligned redirect, cleared by an aligned one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_misalign <= (redirect_pc[1:0] != 2'b00);
    end
  end

  assign w_redirect_pc = redirect_pc;
  assign w_halted      = r_misalign;
`else
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];
  assign w_redirect_pc    = {redirect_pc[31:2], 2'b00};
  assign w_halted         = 1'b0;
`endif

  assign fetch_misalign = w_halted;

  // Decode-side view of the FIFO head
  assign dec_valid  = (r_count != 2'd0);
  assign dec_instr  = r_fifo_instr[r_rd_ptr];
  assign dec_pc     = r_fifo_pc[r_rd_ptr];
  assign dec_opcode = dec_instr[6:0];
  assign dec_funct3 = dec_instr[14:12];
  assign dec_funct7 = dec_instr[31:25];

  // Handshakes, response classification and credit check
  assign w_pop      = dec_valid & dec_ready;
  assign w_rsp_drop = imem_rvalid & (r_drop != '0);
  assign w_rsp_keep = imem_rvalid & (r_drop == '0) & (r_outstanding != '0);
  assign w_push     = w_rsp_keep & ~redirect_valid;
  assign w_credit   = (CNT_W+1)'(r_outstanding) + (CNT_W+1)'(r_count) - (CNT_W+1)'(w_pop);
  assign w_issue    = ~rst & ~redirect_valid & ~w_halted & (w_credit < (CNT_W+1)'(2));

  // Outstanding requests are consecutive words ending just below fetch_pc
  assign w_rsp_pc   = r_fetch_pc - XLEN'({r_outstanding, 2'b00});

  assign imem_req   = w_issue;
  assign imem_addr  = r_fetch_pc;

  // Next-state for pc, counters and occupancy; redirect overrides everything else
  always_comb begin
    w_fetch_pc_nxt    = r_fetch_pc;
    w_outstanding_nxt = r_outstanding;
    w_drop_nxt        = r_drop - CNT_W'(w_rsp_drop);
    w_count_nxt       = r_count;
    if (redirect_valid) begin
      w_fetch_pc_nxt    = w_redirect_pc;
      w_outstanding_nxt = '0;
      w_drop_nxt        = r_drop - CNT_W'(w_rsp_drop) + r_outstanding - CNT_W'(w_rsp_keep);
      w_count_nxt       = '0;
    end else begin
      if (w_issue) begin
        w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
      end
      w_outstanding_nxt = r_outstanding + CNT_W'(w_issue) - CNT_W'(w_rsp_keep);
      w_count_nxt       = r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_count       <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop        <= w_drop_nxt;
      r_count       <= w_count_nxt;
    end
  end

  // FIFO pointers and storage; a redirect rewinds both pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]    <= w_rsp_pc;
        r_fifo_instr[r_wr_ptr] <= imem_rdata;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized phase, checked against a queue-based model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic        fetch_misalign;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_opcode     (dec_opcode),
    .dec_funct3     (dec_funct3),
    .dec_funct7     (dec_funct7),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: fetch pointer, decode queue, in-flight fetch pcs, pending drops
  logic [31:0] m_pc;
  logic [63:0] m_fifo[$];
  logic [31:0] m_out[$];
  int          m_drop;
  bit          m_mis;

  // Memory model: in-order request queue with per-request due cycle
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          cyc;
  int          lat_min;
  int          lat_max;

  bit          seen;
  logic [31:0] rnd_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_drop = 0;
    m_mis  = 1'b0;
    m_fifo.delete();
    m_out.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          rv;
    logic [31:0] rd;
    bit          exp_v;
    bit          pop;
    bit          exp_req;
    logic [63:0] head;
    logic [31:0] tpc;
    logic [31:0] a;
    rv = 1'b0;
    rd = $urandom();
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      rv = 1'b1;
      a  = mem_addr_q.pop_front();
      void'(mem_due_q.pop_front());
      rd = instr_of(a);
    end
    redirect_valid = redir;
    redirect_pc    = rpc;
    dec_ready      = rdy;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    #1;
    exp_v = (m_fifo.size() > 0);
    chk("dec_valid", 32'(dec_valid), 32'(exp_v));
    if (exp_v) begin
      head = m_fifo[0];
      chk("dec_pc", dec_pc, head[63:32]);
      chk("dec_instr", dec_instr, head[31:0]);
      chk("dec_fields", {15'h0, dec_funct7, dec_funct3, dec_opcode},
          {15'h0, head[31:25], head[14:12], head[6:0]});
    end
    pop     = exp_v && rdy;
    exp_req = !redir && !m_mis && ((m_out.size() + m_fifo.size() - int'(pop)) < 2);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("fetch_misalign", 32'(fetch_misalign), 32'(m_mis));
    if (rv) begin
      if (m_drop > 0) begin
        m_drop--;
      end else if (m_out.size() > 0) begin
        tpc = m_out.pop_front();
        if (!redir) m_fifo.push_back({tpc, rd});
      end
    end
    if (redir) begin
      m_drop += m_out.size();
      m_out.delete();
      m_fifo.delete();
`ifdef FETCH_MISALIGN_CHK_EN
      m_mis = (rpc[1:0] != 2'b00);
      m_pc  = rpc;
`else
      m_pc  = {rpc[31:2], 2'b00};
`endif
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (exp_req) begin
        m_out.push_back(m_pc);
        mem_addr_q.push_back(m_pc);
        mem_due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst            = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    cyc            = 0;
    lat_min        = 1;
    lat_max        = 1;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_imem_req", 32'(imem_req), 32'd0);
    chk("reset_dec_valid", 32'(dec_valid), 32'd0);
    chk("reset_misalign", 32'(fetch_misalign), 32'd0);

    // Reset release with 1-cycle memory: streaming from RESET_PC
    rst = 1'b0;
    model_reset();
    repeat (8) step(1'b0, '0, 1'b1);

    // Decode stall: FIFO fills, head holds, then drains
    repeat (5) step(1'b0, '0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1);

    // Redirect with two requests in flight: both responses dropped
    step(1'b1, 32'h0000_0200, 1'b1);
    lat_min = 3;
    lat_max = 3;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    lat_min = 1;
    lat_max = 1;
    step(1'b1, 32'h0000_0100, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (dec_valid) seen = 1'b1;
      else step(1'b0, '0, 1'b1);
    end
    chk("redir_wait", 32'(dec_valid), 32'd1);
    chk("redir_target", dec_pc, 32'h0000_0100);

    // Redirect coincident with pop and response: flush wins
    repeat (4) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h0000_0300, 1'b1);
    chk("flush_wins", 32'(dec_valid), 32'd0);
    repeat (3) step(1'b0, '0, 1'b1);

    // Address wrap at the top of memory
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1);

    // Misaligned redirect target, then recovery with an aligned one
    step(1'b1, 32'h0000_0102, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h0000_0400, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);

    // Reset mid-stream: outputs drop immediately, fetch restarts at RESET_PC
    repeat (3) step(1'b0, '0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_imem_req", 32'(imem_req), 32'd0);
    chk("midrst_dec_valid", 32'(dec_valid), 32'd0);
    chk("midrst_misalign", 32'(fetch_misalign), 32'd0);
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (4) step(1'b0, '0, 1'b1);

    // Randomized traffic: variable latency, random stalls and redirects
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      rnd_pc = $urandom();
      if ($urandom_range(3, 0) != 0) rnd_pc[1:0] = 2'b00;
      step(($urandom_range(15, 0) == 0), rnd_pc, ($urandom_range(9, 0) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
